// File: rtl/nor_chain_pkg.sv
// Shared types and constants for the NOR-chain stimulus generator.
// Holds the FSM encoding, the mode codes and the 16-bit LFSR definition.
package nor_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_RAND  = 2'd1;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: taps on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS         = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/nor_chain_stim_gen_lfsr.sv
// 16-bit Fibonacci LFSR with enable and synchronous reload to the seed.
// Exposes the value the register will hold next, so callers can sample it at phase entry.
module stim_lfsr
    import nor_chain_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        load_i,
    output logic [15:0] lfsr_next_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (en_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_next_o = lfsr_d;

endmodule

// File: rtl/nor_chain_stim_gen.sv
// Pulse-train generator driving the NOR inverter chain input (myin) and its ground tie (mygnd).
// Fixed or LFSR-randomised high/low widths; config via valid/ready, completion via a done pulse.
module nor_chain_stim_gen
    import nor_chain_pkg::*;
#(
    parameter int          CNT_W     = 8,
    parameter int          NUM_W     = 16,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic             myclk,
    input  logic             myrst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [NUM_W-1:0] cfg_count,
    input  logic             abort,
    output logic             myin,
    output logic             mygnd,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_idx
);

    generate
        if (LFSR_SEED == 16'h0000) begin : g_bad_seed
            $error("LFSR_SEED must be nonzero");
        end
        if (2 * CNT_W > 16) begin : g_bad_cnt_w
            $error("CNT_W must be at most 8 so both width fields fit in the LFSR");
        end
    endgenerate

    localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic [NUM_W-1:0] rem_q, rem_d;
    logic [NUM_W-1:0] idx_q, idx_d;
    logic             rand_q, rand_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic             myin_q, myin_d;

    logic             accept;
    logic             lfsr_en;
    logic [15:0]      lfsr_next;

    assign accept  = cfg_valid && (state_q == ST_IDLE);
    assign lfsr_en = (state_q == ST_HIGH) || (state_q == ST_LOW);

    stim_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i       (myclk),
        .rst_ni      (myrst_n),
        .en_i        (lfsr_en),
        .load_i      (accept),
        .lfsr_next_o (lfsr_next)
    );

    // Width is one extra bit wide so an all-ones mask plus one (2^CNT_W) fits.
    function automatic logic [CNT_W:0] calc_width(input logic             rnd,
                                                  input logic [CNT_W-1:0] fld,
                                                  input logic [CNT_W-1:0] rnd_bits);
        if (rnd) begin
            return {1'b0, rnd_bits & fld} + CNT_ONE;
        end else if (fld == '0) begin
            return CNT_ONE;
        end else begin
            return {1'b0, fld};
        end
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        rand_d  = rand_q;
        high_d  = high_q;
        low_d   = low_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rand_d = (cfg_mode == MODE_RAND);
                    high_d = cfg_high;
                    low_d  = cfg_low;
                    rem_d  = cfg_count;
                    idx_d  = '0;
                    if (cfg_count != '0) begin
                        state_d = ST_HIGH;
                        cnt_d   = calc_width(cfg_mode == MODE_RAND, cfg_high,
                                             lfsr_next[CNT_W-1:0]);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ST_LOW;
                    cnt_d   = calc_width(rand_q, low_q, lfsr_next[2*CNT_W-1:CNT_W]);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    idx_d = (&idx_q) ? idx_q : idx_q + NUM_ONE;
                    if (rem_q == NUM_ONE) begin
                        state_d = ST_DONE;
                        rem_d   = '0;
                    end else begin
                        state_d = ST_HIGH;
                        rem_d   = rem_q - NUM_ONE;
                        cnt_d   = calc_width(rand_q, high_q, lfsr_next[CNT_W-1:0]);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        myin_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge myclk or negedge myrst_n) begin
        if (!myrst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            rand_q  <= 1'b0;
            high_q  <= '0;
            low_q   <= '0;
            myin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            rand_q  <= rand_d;
            high_q  <= high_d;
            low_q   <= low_d;
            myin_q  <= myin_d;
        end
    end

    assign myin      = myin_q;
    assign mygnd     = 1'b0;
    assign busy      = (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign done      = (state_q == ST_DONE);
    assign cfg_ready = (state_q == ST_IDLE);
    assign pulse_idx = idx_q;

endmodule

// File: tb/tb_nor_chain_stim_gen.sv
// Directed bench for nor_chain_stim_gen: fixed-width vector table, LFSR-model runs,
// abort and asynchronous-reset sequences.
module tb_nor_chain_stim_gen;

    logic        myclk = 1'b0;
    logic        myrst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_mode = 2'd0;
    logic [7:0]  cfg_high = 8'd0;
    logic [7:0]  cfg_low = 8'd0;
    logic [15:0] cfg_count = 16'd0;
    logic        abort = 1'b0;
    logic        myin;
    logic        mygnd;
    logic        busy;
    logic        done;
    logic [15:0] pulse_idx;

    int total = 0;
    int bad = 0;

    nor_chain_stim_gen dut (
        .myclk     (myclk),
        .myrst_n   (myrst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_high  (cfg_high),
        .cfg_low   (cfg_low),
        .cfg_count (cfg_count),
        .abort     (abort),
        .myin      (myin),
        .mygnd     (mygnd),
        .busy      (busy),
        .done      (done),
        .pulse_idx (pulse_idx)
    );

    always #5 myclk = ~myclk;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  high;
        logic [7:0]  low;
        logic [15:0] count;
        int          exp_h;
        int          exp_l;
        int          exp_busy;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic offer(input logic [1:0] mode, input logic [7:0] hi, input logic [7:0] lo,
                         input logic [15:0] cnt, input logic with_abort);
        cfg_valid = 1'b1;
        cfg_mode  = mode;
        cfg_high  = hi;
        cfg_low   = lo;
        cfg_count = cnt;
        abort     = with_abort;
        @(negedge myclk);
        cfg_valid = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic run_vec(input int n);
        vec_t v;
        int   bad0;
        logic exp_in;
        v    = vecs[n];
        bad0 = bad;
        check("ready_before", cfg_ready, 1);
        offer(v.mode, v.high, v.low, v.count, 1'b0);
        for (int k = 1; k <= v.exp_busy + 2; k++) begin
            if (k <= v.exp_busy) begin
                exp_in = ((k - 1) % (v.exp_h + v.exp_l)) < v.exp_h;
                check("vec_myin", myin, exp_in);
                check("vec_busy", busy, 1);
                check("vec_done_early", done, 0);
            end else if (k == v.exp_busy + 1) begin
                check("vec_done", done, 1);
                check("vec_ready_in_done", cfg_ready, 0);
                check("vec_busy_in_done", busy, 0);
                check("vec_myin_in_done", myin, 0);
                check("vec_pulse_idx", pulse_idx, v.count);
            end else begin
                check("vec_done_one_cycle", done, 0);
                check("vec_ready_after", cfg_ready, 1);
                check("vec_mygnd", mygnd, 0);
            end
            @(negedge myclk);
        end
        $display("vec %0d mode=%0d high=%0d low=%0d count=%0d busy_cycles=%0d errors=%0d",
                 n, v.mode, v.high, v.low, v.count, v.exp_busy, bad - bad0);
    endtask

    task automatic run_rand(input int run);
        logic [15:0] lf;
        int          wh;
        int          wl;
        int          bad0;
        int          cycles;
        bad0   = bad;
        cycles = 0;
        lf     = 16'hACE1;
        offer(2'd1, 8'h0F, 8'h07, 16'd16, 1'b0);
        for (int p = 0; p < 16; p++) begin
            wh = int'(lf[7:0] & 8'h0F) + 1;
            for (int i = 0; i < wh; i++) begin
                check("rand_myin_high", myin, 1);
                lf = ref_step(lf);
                cycles++;
                @(negedge myclk);
            end
            wl = int'(lf[15:8] & 8'h07) + 1;
            for (int i = 0; i < wl; i++) begin
                check("rand_myin_low", myin, 0);
                check("rand_busy", busy, 1);
                lf = ref_step(lf);
                cycles++;
                @(negedge myclk);
            end
        end
        check("rand_done", done, 1);
        check("rand_pulse_idx", pulse_idx, 16);
        @(negedge myclk);
        check("rand_done_cleared", done, 0);
        $display("rand run %0d mode=1 masks=0f/07 count=16 cycles=%0d errors=%0d",
                 run, cycles, bad - bad0);
    endtask

    initial begin
        vecs[0] = '{mode: 2'd0, high: 8'd3, low: 8'd2, count: 16'd4, exp_h: 3, exp_l: 2, exp_busy: 20};
        vecs[1] = '{mode: 2'd0, high: 8'd0, low: 8'd0, count: 16'd2, exp_h: 1, exp_l: 1, exp_busy: 4};
        vecs[2] = '{mode: 2'd0, high: 8'd5, low: 8'd1, count: 16'd0, exp_h: 5, exp_l: 1, exp_busy: 0};
        vecs[3] = '{mode: 2'd3, high: 8'd1, low: 8'd4, count: 16'd3, exp_h: 1, exp_l: 4, exp_busy: 15};
        vecs[4] = '{mode: 2'd0, high: 8'd2, low: 8'd0, count: 16'd1, exp_h: 2, exp_l: 1, exp_busy: 3};

        // Reset state
        repeat (2) @(negedge myclk);
        check("rst_myin", myin, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_pulse_idx", pulse_idx, 0);
        check("rst_mygnd", mygnd, 0);
        $display("reset applied, outputs checked");
        myrst_n = 1'b1;
        @(negedge myclk);

        for (int i = 0; i < 5; i++) begin
            run_vec(i);
        end

        run_rand(0);
        @(negedge myclk);
        run_rand(1);

        // Abort during the third pulse of a ten-pulse run
        offer(2'd0, 8'd3, 8'd2, 16'd10, 1'b0);
        for (int k = 0; k < 10; k++) begin
            check("abort_no_done", done, 0);
            @(negedge myclk);
        end
        check("abort_third_high", myin, 1);
        check("abort_idx_before", pulse_idx, 2);
        abort = 1'b1;
        @(negedge myclk);
        abort = 1'b0;
        check("abort_myin", myin, 0);
        check("abort_busy", busy, 0);
        check("abort_idle", cfg_ready, 1);
        check("abort_no_done_after", done, 0);
        check("abort_idx_hold", pulse_idx, 2);
        // Abort asserted together with a new accept: the accept wins
        offer(2'd0, 8'd1, 8'd1, 16'd1, 1'b1);
        check("reaccept_myin", myin, 1);
        check("reaccept_idx_clear", pulse_idx, 0);
        check("reaccept_done", done, 0);
        @(negedge myclk);
        check("reaccept_low", myin, 0);
        @(negedge myclk);
        check("reaccept_done_pulse", done, 1);
        check("reaccept_idx", pulse_idx, 1);
        @(negedge myclk);
        check("reaccept_done_clear", done, 0);
        $display("abort sequence done errors_so_far=%0d", bad);

        // Asynchronous reset in the middle of a HIGH phase
        offer(2'd0, 8'd5, 8'd2, 16'd3, 1'b0);
        @(negedge myclk);
        check("arst_pre_myin", myin, 1);
        myrst_n = 1'b0;
        #1;
        check("arst_myin", myin, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ready", cfg_ready, 1);
        check("arst_mygnd", mygnd, 0);
        check("arst_idx", pulse_idx, 0);
        @(negedge myclk);
        myrst_n = 1'b1;
        @(negedge myclk);
        check("arst_after_ready", cfg_ready, 1);
        check("arst_after_myin", myin, 0);
        check("arst_after_mygnd", mygnd, 0);
        $display("async reset sequence done errors_so_far=%0d", bad);
        run_vec(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
